// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures one asynchronous PWM input period by period and recovers the
//   8-bit intensity that produced it: duty = floor(active*256/period),
//   saturating naturally at 255 when the line is asserted for the whole period.
//
// Ports
//   iCLOCK    system clock, all logic on the rising edge
//   iRESET    synchronous reset, active-high
//   iPWM      asynchronous PWM input
//   oVALID    one-cycle strobe, the result outputs change together with it
//   oPERIOD   cycles between consecutive period-start edges (0 on timeout)
//   oACTIVE   asserted cycles within that period (0 on timeout)
//   oDUTY     recovered intensity (timeout: 255 if stuck asserted, else 0)
//   oTIMEOUT  last published result was a timeout
//   oOVERRUN  sticky, a measurement was dropped because the divider was busy
module pwm_capture #(
   parameter int CNT_W      = 16,
   parameter int MAX_PERIOD = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic             iCLOCK,
   input  logic             iRESET,
   input  logic             iPWM,
   output logic             oVALID,
   output logic [CNT_W-1:0] oPERIOD,
   output logic [CNT_W-1:0] oACTIVE,
   output logic [7:0]       oDUTY,
   output logic             oTIMEOUT,
   output logic             oOVERRUN
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(MAX_PERIOD - 1);

   typedef enum logic {IDLE, MEASURE} state_t;

   // One restoring-division step. The remainder never exceeds the divisor,
   // so CNT_W bits hold it between steps; the shifted value needs one more.
   // Returns {quotient bit, new remainder}.
   function automatic logic [CNT_W:0] div_step(input logic [CNT_W-1:0] rem,
                                               input logic [CNT_W-1:0] den);
      logic [CNT_W:0] sh;
      logic [CNT_W:0] diff;
      sh   = {rem, 1'b0};
      diff = sh - {1'b0, den};
      if (sh >= {1'b0, den}) div_step = {1'b1, diff[CNT_W-1:0]};
      else                   div_step = {1'b0, sh[CNT_W-1:0]};
   endfunction

   logic s1, s2, s3;
   logic act, act_d, start;

   state_t           state;
   logic [CNT_W-1:0] cnt_per, cnt_act;
   logic             tmo_pend, tmo_act;

   logic             div_busy;
   logic [3:0]       div_cnt;
   logic [CNT_W-1:0] div_rem, div_den, div_act;
   logic [7:0]       div_q;
   logic [CNT_W:0]   step;
   logic             div_done;

   // Input synchronizer plus one extra stage for edge detection
   always_ff @(posedge iCLOCK) begin
      if (iRESET) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= iPWM;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign act      = (ACTIVE_LOW != 0) ? ~s2 : s2;
   assign act_d    = (ACTIVE_LOW != 0) ? ~s3 : s3;
   assign start    = act & ~act_d;
   assign step     = div_step(div_rem, div_den);
   assign div_done = div_busy && (div_cnt == 4'd8);

   always_ff @(posedge iCLOCK) begin
      if (iRESET) begin
         state     <= IDLE;
         cnt_per   <= '0;
         cnt_act   <= '0;
         tmo_pend  <= 1'b0;
         tmo_act   <= 1'b0;
         div_busy  <= 1'b0;
         div_cnt   <= '0;
         div_rem   <= '0;
         div_den   <= '0;
         div_act   <= '0;
         div_q     <= '0;
         oVALID    <= 1'b0;
         oPERIOD   <= '0;
         oACTIVE   <= '0;
         oDUTY     <= '0;
         oTIMEOUT  <= 1'b0;
         oOVERRUN  <= 1'b0;
      end else begin
         oVALID <= 1'b0;

         // Publish stage: a finished divide takes priority, a pending
         // timeout waits for the next free edge
         if (div_done) begin
            oVALID   <= 1'b1;
            oPERIOD  <= div_den;
            oACTIVE  <= div_act;
            oDUTY    <= div_q;
            oTIMEOUT <= 1'b0;
            div_busy <= 1'b0;
         end else if (tmo_pend) begin
            oVALID   <= 1'b1;
            oPERIOD  <= '0;
            oACTIVE  <= '0;
            oDUTY    <= tmo_act ? 8'hFF : 8'h00;
            oTIMEOUT <= 1'b1;
            tmo_pend <= 1'b0;
         end

         // Divider stage: one quotient bit per cycle, MSB first
         if (div_busy && (div_cnt != 4'd8)) begin
            div_rem <= step[CNT_W-1:0];
            div_q   <= {div_q[6:0], step[CNT_W]};
            div_cnt <= div_cnt + 4'd1;
         end

         // Measurement stage
         case (state)
            IDLE: begin
               // first edge after reset or timeout only arms the counters
               if (start) begin
                  state   <= MEASURE;
                  cnt_per <= CNT_ONE;
                  cnt_act <= CNT_ONE;
               end
            end
            MEASURE: begin
               if (start) begin
                  if (!div_busy) begin
                     div_busy <= 1'b1;
                     div_cnt  <= '0;
                     div_rem  <= cnt_act;
                     div_den  <= cnt_per;
                     div_act  <= cnt_act;
                     div_q    <= '0;
                  end else begin
                     oOVERRUN <= 1'b1;
                  end
                  cnt_per <= CNT_ONE;
                  cnt_act <= CNT_ONE;
               end else if (cnt_per == TMO_CNT) begin
                  state    <= IDLE;
                  tmo_pend <= 1'b1;
                  tmo_act  <= act;
               end else begin
                  cnt_per <= cnt_per + CNT_ONE;
                  if (act) cnt_act <= cnt_act + CNT_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
